// File: rtl/mem_pkg.sv
// Shared types and constants for the single-port memory-system protocol.
// The address check helper is shared so every initiator applies identical rules.
`timescale 1ns/1ps
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int unsigned MEM_WORD_BYTES   = 4;
    localparam logic [31:0] MEM_DEFAULT_BASE = 32'h0000_2000;
    localparam logic [31:0] MEM_DEFAULT_WIN  = 32'h0000_1000;

    // Offset is compared rather than base+win so a window ending at 2^32 cannot wrap.
    function automatic logic mem_addr_ok(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] win);
        logic [31:0] offset;
        offset = addr - base;
        return ((addr & 32'(MEM_WORD_BYTES - 1)) == 32'd0) && (addr >= base) && (offset < win);
    endfunction

endpackage

// File: rtl/mem_req_master.sv
// Single-outstanding memory request initiator: accepts one load/store, drives the
// memory port until mem_done or timeout, then holds the response until taken.
`timescale 1ns/1ps
module mem_req_master
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = MEM_DEFAULT_BASE,
    parameter logic [31:0] WIN_BYTES = MEM_DEFAULT_WIN,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_stall,
    input  logic        mem_done
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_t  state_q, state_d;
    logic        ready_q, ready_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // NOTE: every variable gets a hold-value default before the case statement,
    // which keeps this block purely combinational (no inferred latches).
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            IDLE: begin
                if (ready_q && req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = {req_addr[31:2], 2'b00};
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (mem_addr_ok(req_addr, BASE_ADDR, WIN_BYTES)) begin
                        err_d   = 1'b0;
                        state_d = BUSY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // Completion takes priority over a timeout landing in the same cycle.
                if (mem_done) begin
                    rdata_d = wr_q ? '0 : mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
                if (mem_stall && (stall_cnt_q != 16'hFFFF)) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered ready keeps req_ready low during reset and the cycle it releases.
        ready_d = (state_d == IDLE);
    end

    always_comb begin
        req_ready  = ready_q;
        resp_valid = (state_q == RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
        mem_en     = (state_q == BUSY);
        mem_wr     = (state_q == BUSY) && wr_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
    end

endmodule

// File: tb/tb_mem_req_master.sv
// Directed bench for mem_req_master with a programmable-latency memory responder.
`timescale 1ns/1ps
module tb_mem_req_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_stall, mem_done;
    logic        model_done, stray_done;

    int          n_checks = 0;
    int          n_fail = 0;
    int          done_delay, busy_n, en_cycles, wr_cycles, unstable, lat;
    logic [31:0] addr0, wdata0;
    logic [31:0] err_addrs [3];

    always #5 clk = ~clk;

    assign mem_done = model_done | stray_done;

    mem_req_master #(
        .BASE_ADDR(32'h0000_2000),
        .WIN_BYTES(32'h0000_1000),
        .TIMEOUT  (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_stall (mem_stall),
        .mem_done  (mem_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle, sample 1ns after the edge, and run the responder model:
    // mem_done is raised in the done_delay-th BUSY cycle (0 = never).
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_en) begin
            en_cycles++;
            if (mem_wr) wr_cycles++;
            busy_n++;
            if (busy_n == 1) begin
                addr0  = mem_addr;
                wdata0 = mem_wdata;
            end else if (mem_addr !== addr0 || mem_wdata !== wdata0) begin
                unstable++;
            end
            model_done = (done_delay != 0) && (busy_n == done_delay);
        end else begin
            busy_n     = 0;
            model_done = 1'b0;
        end
    endtask

    // Issue one request and wait (bounded) for resp_valid; lat counts cycles after accept.
    task automatic run_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay, input logic [31:0] rd, output int l);
        done_delay = delay;
        mem_rdata  = rd;
        en_cycles  = 0;
        wr_cycles  = 0;
        unstable   = 0;
        req_wr     = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
        l = 1;
        while (resp_valid !== 1'b1 && l < 200) begin
            tick();
            l++;
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; mem_rdata = '0; mem_stall = 1'b0;
        model_done = 1'b0; stray_done = 1'b0;
        done_delay = 0; busy_n = 0; en_cycles = 0; wr_cycles = 0; unstable = 0;
        addr0 = '0; wdata0 = '0;

        tick();
        tick();
        check("rst_ctrl", {27'd0, req_ready, resp_valid, resp_err, mem_en, mem_wr}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Load with completion in the first BUSY cycle.
        mem_stall = 1'b1;
        run_req(1'b0, 32'h2004, 32'h0, 1, 32'hDEADBEEF, lat);
        check("ld_latency", lat, 32'd2);
        check("ld_en_cycles", en_cycles, 32'd1);
        check("ld_wr_cycles", wr_cycles, 32'd0);
        check("ld_addr", addr0, 32'h2004);
        check("ld_rdata", resp_rdata, 32'hDEADBEEF);
        check("ld_err", {31'd0, resp_err}, 32'd0);
        check("ld_ready_in_resp", {31'd0, req_ready}, 32'd0);
        finish_resp();
        check("ld_after_hs", {30'd0, resp_valid, req_ready}, 32'b01);
        mem_stall = 1'b0;

        // Store at the top word of the window, completion after 5 cycles.
        run_req(1'b1, 32'h2FFC, 32'h12345678, 5, 32'hCAFEF00D, lat);
        check("st_latency", lat, 32'd6);
        check("st_en_cycles", en_cycles, 32'd5);
        check("st_wr_cycles", wr_cycles, 32'd5);
        check("st_unstable", unstable, 32'd0);
        check("st_addr", addr0, 32'h2FFC);
        check("st_wdata", wdata0, 32'h12345678);
        check("st_rdata", resp_rdata, 32'd0);
        check("st_err", {31'd0, resp_err}, 32'd0);
        finish_resp();

        // Misaligned, just past the window, just below the window.
        err_addrs[0] = 32'h2002;
        err_addrs[1] = 32'h3000;
        err_addrs[2] = 32'h1FFC;
        for (int i = 0; i < 3; i++) begin
            run_req(1'b0, err_addrs[i], 32'h0, 1, 32'h11111111, lat);
            check($sformatf("bad%0d_latency", i), lat, 32'd1);
            check($sformatf("bad%0d_en_cycles", i), en_cycles, 32'd0);
            check($sformatf("bad%0d_err", i), {31'd0, resp_err}, 32'd1);
            check($sformatf("bad%0d_rdata", i), resp_rdata, 32'd0);
            finish_resp();
        end

        // No completion: timeout after exactly 64 BUSY cycles.
        run_req(1'b0, 32'h200C, 32'h0, 0, 32'h77777777, lat);
        check("to_en_cycles", en_cycles, 32'd64);
        check("to_latency", lat, 32'd65);
        check("to_err", {31'd0, resp_err}, 32'd1);
        check("to_rdata", resp_rdata, 32'd0);
        finish_resp();

        // Response back-pressure with a new request waiting.
        run_req(1'b0, 32'h2010, 32'h0, 2, 32'hA5A55A5A, lat);
        check("bp_latency", lat, 32'd3);
        req_wr = 1'b0; req_addr = 32'h2014; req_wdata = '0; req_valid = 1'b1;
        done_delay = 1;
        mem_rdata  = 32'h01020304;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp_ctrl%0d", i), {29'd0, resp_valid, req_ready, mem_en}, 32'b100);
            check($sformatf("bp_data%0d", i), resp_rdata, 32'hA5A55A5A);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp_handshake", {29'd0, resp_valid, req_ready, mem_en}, 32'b010);
        tick();
        req_valid = 1'b0;
        check("bp_accept_en", {31'd0, mem_en}, 32'd1);
        check("bp_accept_addr", mem_addr, 32'h2014);
        tick();
        check("bp2_valid", {31'd0, resp_valid}, 32'd1);
        check("bp2_rdata", resp_rdata, 32'h01020304);
        finish_resp();

        // Reset in the middle of BUSY.
        done_delay = 0;
        req_wr = 1'b1; req_addr = 32'h2018; req_wdata = 32'h99999999; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("mid_busy_en", {31'd0, mem_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_ctrl", {27'd0, req_ready, resp_valid, resp_err, mem_en, mem_wr}, 32'd0);
        check("abort_addr", mem_addr, 32'd0);
        check("abort_wdata", mem_wdata, 32'd0);
        check("abort_rdata", resp_rdata, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        run_req(1'b0, 32'h2008, 32'h0, 3, 32'h0BADF00D, lat);
        check("post_rst_latency", lat, 32'd4);
        check("post_rst_rdata", resp_rdata, 32'h0BADF00D);
        check("post_rst_err", {31'd0, resp_err}, 32'd0);
        finish_resp();

        // Stray completion pulse while idle.
        mem_rdata  = 32'hFFFFFFFF;
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        check("stray_ctrl", {29'd0, resp_valid, req_ready, mem_en}, 32'b010);
        tick();
        check("stray_ctrl2", {29'd0, resp_valid, req_ready, mem_en}, 32'b010);
        run_req(1'b0, 32'h2020, 32'h0, 1, 32'h00000055, lat);
        check("after_stray_latency", lat, 32'd2);
        check("after_stray_rdata", resp_rdata, 32'h00000055);
        finish_resp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_req_master.md
# mem_req_master

Initiator side of the single-port memory-system protocol: it accepts one load or store at a time from a pipeline client (fetch or memory stage) over a valid/ready handshake and drives the memory-system port (en/wr/addr/data_in). It waits a variable number of cycles for `mem_done` and returns read data or an error over a valid/ready response channel. It sits between the pipeline stages and the memory system, enforcing word alignment, the address window and a timeout.

## Interface
- `BASE_ADDR`, 32'h0000_2000, first byte address of the legal window.
- `WIN_BYTES`, 32'h0000_1000, window size in bytes; legal addresses are `BASE_ADDR` .. `BASE_ADDR+WIN_BYTES-1`.
- `TIMEOUT`, 64, maximum cycles to wait for `mem_done` before an error response; must be >= 2.

- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  client request present.
- `req_ready`  out  1  block can accept a request.
- `req_wr`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  client takes the response.
- `resp_rdata`  out  32  load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned, out-of-window or timed out.
- `mem_en`  out  1  memory request active.
- `mem_wr`  out  1  store qualifier.
- `mem_addr`  out  32  word-aligned address.
- `mem_wdata`  out  32  store data.
- `mem_rdata`  in  32  read data, valid in the cycle `mem_done`=1.
- `mem_stall`  in  1  memory busy; informational only, counted for debug.
- `mem_done`  in  1  one-cycle completion pulse.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch wr/addr/wdata and check the address.
  - Check fails if `addr[1:0]`!=0 or the address is outside the window.
  - If the check fails: go to RESP with `resp_err`=1 and `resp_rdata`=0. No memory access.
  - If the check passes: go to BUSY and clear the timeout counter.
- BUSY: `mem_en`=1. `mem_wr`, `mem_addr` and `mem_wdata` are held stable from the latched values. The counter increments each cycle.
  - On `mem_done`=1: capture `mem_rdata` (loads only; stores capture 0), set `resp_err`=0, go to RESP.
  - If the counter reaches `TIMEOUT` without `mem_done`: go to RESP with `resp_err`=1 and `resp_rdata`=0.
  - If `mem_done` and timeout occur in the same cycle, `mem_done` wins.
- RESP: `resp_valid`=1 and the response fields are stable. Return to IDLE on `resp_ready`. `req_ready`=0 in this state; there is no overlap of response and new accept.
- `mem_done` seen in IDLE or RESP is ignored. `mem_rdata` is not captured.
- `mem_stall_cycles` is an internal 16-bit saturating debug counter of BUSY cycles with `mem_stall`=1. It clears on reset and is not a port.

## Timing
- Reset value of every output is 0: `req_ready`, `resp_valid`, `resp_rdata`, `resp_err`, `mem_en`, `mem_wr`, `mem_addr`, `mem_wdata`. State returns to IDLE.
- `req_ready` becomes 1 in the first cycle after `rst_n` deasserts.
- An assertion mid-transaction aborts immediately: `mem_en` drops asynchronously and the response is lost.
- All outputs are registered or decoded from state only. There is no combinational path from `mem_*` inputs to outputs.
- Accept at edge N → `mem_en`=1 in cycle N+1.
- `mem_done` in cycle N+k → `resp_valid`=1 in cycle N+k+1. Minimum accept-to-response latency is 2 cycles.
- Error on check: `resp_valid`=1 in cycle N+1, with `mem_en` never asserted.
- Timeout: `mem_en` is high for exactly `TIMEOUT` cycles, then `resp_valid` is asserted in the next cycle.
- Throughput: at most one request per 3 cycles (IDLE→BUSY→RESP).

## Structure
- Shared package `mem_pkg`:
  - typedef `mem_state_t` {IDLE, BUSY, RESP}.
  - Constants `MEM_WORD_BYTES`=4, `MEM_DEFAULT_BASE`=32'h2000, `MEM_DEFAULT_WIN`=32'h1000.
- No sub-module; a single always_ff plus next-state logic.
- The memory system used as bench responder needs variable latency. The bench drives `mem_done` from a programmable delay model.

## Test plan
- Load 0x2004, responder returns 0xDEADBEEF with `mem_done` in the first BUSY cycle → `mem_en` high 1 cycle, `mem_addr`=0x2004, `mem_wr`=0; `resp_rdata`=0xDEADBEEF, `resp_err`=0, latency 2.
- Store 0x2FFC/0x12345678, `mem_done` after 5 cycles → `mem_en`/`mem_wr` high 5 cycles with `mem_addr` and `mem_wdata` stable; `resp_err`=0, `resp_rdata`=0.
- Misaligned 0x2002 and out-of-window 0x3000 → `resp_err`=1 next cycle, `mem_en` never asserted.
- No `mem_done` with `TIMEOUT`=64 → `mem_en` high exactly 64 cycles, then `resp_err`=1.
- Hold `resp_ready`=0 for 10 cycles → `resp_valid` and data stable, `req_ready`=0, new `req_valid` not accepted; accepted the cycle after the handshake completes.
- `rst_n` low during BUSY → all outputs 0 immediately. A following load at 0x2008 completes normally. A late stray `mem_done` in IDLE is ignored.
